// File: rtl/uart_boot_loader_if.sv
// rtl/uart_boot_loader_if.sv - UART and instruction-memory signal bundle for uart_boot_loader
// master = boot loader side, slave = UART/IMEM side.
interface uart_boot_loader_if #(
  parameter int IMEM_ADDR_W = 15
);
  logic [7:0]             rx_rdata;
  logic                   rx_rdata_ready;
  logic                   rx_ferr;
  logic [7:0]             tx_sdata;
  logic                   tx_start;
  logic                   tx_busy;
  logic                   imem_we;
  logic [IMEM_ADDR_W-1:0] imem_waddr;
  logic [31:0]            imem_wdata;
  logic                   boot_done;
  logic                   boot_err;

  modport master (
    input  rx_rdata, rx_rdata_ready, rx_ferr, tx_busy,
    output tx_sdata, tx_start, imem_we, imem_waddr, imem_wdata, boot_done, boot_err
  );

  modport slave (
    output rx_rdata, rx_rdata_ready, rx_ferr, tx_busy,
    input  tx_sdata, tx_start, imem_we, imem_waddr, imem_wdata, boot_done, boot_err
  );
endinterface

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART boot sequencer: request, size, image into IMEM, acknowledge
// Optional trailing XOR checksum byte when BOOT_CHECKSUM_EN is defined.
module uart_boot_loader #(
  parameter int         IMEM_ADDR_W = 15,
  parameter logic [7:0] REQ_BYTE    = 8'h99,
  parameter logic [7:0] ACK_BYTE    = 8'hAA
) (
  input  logic               clk,
  input  logic               reset_n,
  uart_boot_loader_if.master bus
);

  typedef enum logic [2:0] {
    S_REQ,
    S_SIZE,
    S_PROG,
`ifdef BOOT_CHECKSUM_EN
    S_CSUM,
`endif
    S_ACK,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [32:0] MAX_BYTES = 33'd4 << IMEM_ADDR_W;

  state_e                 state_q, state_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [31:0]            size_q, size_d;
  logic [23:0]            word_q, word_d;
  logic                   tx_start_q, tx_start_d;
  logic [7:0]             tx_sdata_q, tx_sdata_d;
  logic                   we_q, we_d;
  logic [IMEM_ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]            wdata_q, wdata_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]             xor_q, xor_d;
`endif

  logic        tx_guard;
  logic        tx_ok;
  logic [31:0] size_next;
  logic        size_bad;
  logic [31:0] cnt_inc;
  state_e      after_prog;

  // UART_TX reports busy one cycle late, so the pulse cycle itself blocks a resend.
  assign tx_guard  = tx_start_q;
  assign tx_ok     = !bus.tx_busy && !tx_guard;
  assign size_next = {bus.rx_rdata, size_q[31:8]};
  assign size_bad  = (size_next[1:0] != 2'b00) || ({1'b0, size_next} > MAX_BYTES);
  assign cnt_inc   = cnt_q + 32'd1;

`ifdef BOOT_CHECKSUM_EN
  assign after_prog = S_CSUM;
`else
  assign after_prog = S_ACK;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_REQ;
      cnt_q      <= '0;
      size_q     <= '0;
      word_q     <= '0;
      tx_start_q <= 1'b0;
      tx_sdata_q <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
`ifdef BOOT_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      size_q     <= size_d;
      word_q     <= word_d;
      tx_start_q <= tx_start_d;
      tx_sdata_q <= tx_sdata_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
`ifdef BOOT_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    size_d     = size_q;
    word_d     = word_q;
    tx_start_d = 1'b0;
    tx_sdata_d = tx_sdata_q;
    we_d       = 1'b0;
    wdata_d    = wdata_q;
    // Address advances after each write so the next word lands one higher.
    waddr_d    = we_q ? waddr_q + IMEM_ADDR_W'(1) : waddr_q;
`ifdef BOOT_CHECKSUM_EN
    xor_d      = xor_q;
`endif

    case (state_q)
      S_REQ: begin
        if (tx_ok) begin
          tx_start_d = 1'b1;
          tx_sdata_d = REQ_BYTE;
          state_d    = S_SIZE;
        end
      end
      S_SIZE: begin
        if (bus.rx_rdata_ready) begin
          if (bus.rx_ferr) begin
            state_d = S_ERR;
          end else begin
            size_d = size_next;
            cnt_d  = cnt_inc;
            if (cnt_q[1:0] == 2'd3) begin
              cnt_d = '0;
              if (size_bad)               state_d = S_ERR;
              else if (size_next == '0)   state_d = after_prog;
              else                        state_d = S_PROG;
            end
          end
        end
      end
      S_PROG: begin
        if (bus.rx_rdata_ready) begin
          if (bus.rx_ferr) begin
            state_d = S_ERR;
          end else begin
            word_d = {bus.rx_rdata, word_q[23:8]};
            cnt_d  = cnt_inc;
`ifdef BOOT_CHECKSUM_EN
            xor_d  = xor_q ^ bus.rx_rdata;
`endif
            if (cnt_q[1:0] == 2'd3) begin
              we_d    = 1'b1;
              wdata_d = {bus.rx_rdata, word_q};
            end
            if (cnt_inc == size_q) state_d = after_prog;
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CSUM: begin
        if (bus.rx_rdata_ready) begin
          if (bus.rx_ferr || (bus.rx_rdata != xor_q)) state_d = S_ERR;
          else                                        state_d = S_ACK;
        end
      end
`endif
      S_ACK: begin
        if (tx_ok) begin
          tx_start_d = 1'b1;
          tx_sdata_d = ACK_BYTE;
          state_d    = S_DONE;
        end
      end
      S_DONE: ;
      S_ERR:  ;
      default: state_d = S_ERR;
    endcase
  end

  assign bus.tx_start   = tx_start_q;
  assign bus.tx_sdata   = tx_sdata_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.boot_done  = (state_q == S_DONE);
  assign bus.boot_err   = (state_q == S_ERR);

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - randomized self-checking bench for uart_boot_loader
// Honours BOOT_CHECKSUM_EN when the design is built with it.
module tb_uart_boot_loader;
  localparam int         AW  = 15;
  localparam logic [7:0] REQ = 8'h99;
  localparam logic [7:0] ACK = 8'hAA;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  int tbase = 0;
  int wbase = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  tx_q[$];
  int          tx_cyc_q[$];
  logic [7:0]  img_q[$];

  uart_boot_loader_if #(.IMEM_ADDR_W(AW)) bus ();

  uart_boot_loader #(.IMEM_ADDR_W(AW), .REQ_BYTE(REQ), .ACK_BYTE(ACK)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (reset_n) begin
      if (bus.imem_we) begin
        wr_addr_q.push_back(32'(bus.imem_waddr));
        wr_data_q.push_back(bus.imem_wdata);
        last_we_cyc = cyc;
      end
      if (bus.tx_start) begin
        tx_q.push_back(bus.tx_sdata);
        tx_cyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ferr, input bit b2b);
    bus.rx_rdata       = b;
    bus.rx_rdata_ready = 1'b1;
    bus.rx_ferr        = ferr;
    tick();
    bus.rx_rdata_ready = 1'b0;
    bus.rx_ferr        = 1'b0;
    if (!b2b) repeat ($urandom_range(0, 3)) tick();
  endtask

  task automatic do_reset(input logic busy);
    reset_n            = 1'b0;
    bus.tx_busy        = busy;
    bus.rx_rdata       = 8'h00;
    bus.rx_rdata_ready = 1'b0;
    bus.rx_ferr        = 1'b0;
    tick();
    tick();
    chk("rst_tx_start",   32'(bus.tx_start),   0);
    chk("rst_tx_sdata",   32'(bus.tx_sdata),   0);
    chk("rst_imem_we",    32'(bus.imem_we),    0);
    chk("rst_imem_waddr", 32'(bus.imem_waddr), 0);
    chk("rst_imem_wdata", bus.imem_wdata,      0);
    chk("rst_boot_done",  32'(bus.boot_done),  0);
    chk("rst_boot_err",   32'(bus.boot_err),   0);
    tbase   = tx_q.size();
    wbase   = wr_data_q.size();
    reset_n = 1'b1;
  endtask

  task automatic wait_req();
    int lim = 0;
    while (tx_q.size() == tbase && lim < 20) begin
      tick();
      lim++;
    end
    chk("req_sent", 32'(tx_q.size() > tbase), 1);
  endtask

  // Reference: a load succeeds iff the size is word-aligned and fits the memory,
  // no byte has a framing error and (when enabled) the checksum is the XOR of the image.
  task automatic run_load(input logic [31:0] sz, input int ferr_at, input bit bad_csum, input bit b2b);
    bit          size_ok;
    bit          exp_done;
    bit          stop;
    int          nw;
    int          lim;
    int          i;
    logic [7:0]  x;
    logic [31:0] w;
    wait_req();
    size_ok = (sz % 4 == 0) && (longint'(sz) <= 4 * (longint'(1) << AW));
    while (size_ok && img_q.size() < int'(sz)) img_q.push_back(8'($urandom));
    for (int k = 0; k < 4; k++) send_byte(8'(sz >> (8 * k)), 1'b0, b2b);
    x = 8'h00;
    if (size_ok) begin
      i = 0;
      stop = 1'b0;
      while (i < int'(sz) && !stop) begin
        send_byte(img_q[i], i == ferr_at, b2b);
        if (i == ferr_at) stop = 1'b1;
        else x = x ^ img_q[i];
        i++;
      end
`ifdef BOOT_CHECKSUM_EN
      if (ferr_at < 0) send_byte(bad_csum ? (x ^ 8'h01) : x, 1'b0, b2b);
`endif
    end
    exp_done = size_ok && (ferr_at < 0);
`ifdef BOOT_CHECKSUM_EN
    exp_done = exp_done && !bad_csum;
`endif
    nw = !size_ok ? 0 : (ferr_at >= 0 ? ferr_at / 4 : int'(sz) / 4);
    lim = 0;
    while (!(bus.boot_done || bus.boot_err) && lim < 40) begin
      tick();
      lim++;
    end
    repeat (3) tick();
    chk("boot_done", 32'(bus.boot_done), 32'(exp_done));
    chk("boot_err",  32'(bus.boot_err),  32'(!exp_done));
    chk("n_writes",  32'(wr_data_q.size() - wbase), 32'(nw));
    for (int j = 0; j < nw && wbase + j < wr_data_q.size(); j++) begin
      w = 32'(img_q[4*j]) + 32'(img_q[4*j+1]) * 256 + 32'(img_q[4*j+2]) * 65536
        + 32'(img_q[4*j+3]) * 16777216;
      chk("imem_waddr", wr_addr_q[wbase + j], 32'(j));
      chk("imem_wdata", wr_data_q[wbase + j], w);
    end
    chk("n_tx", 32'(tx_q.size() - tbase), exp_done ? 32'd2 : 32'd1);
    if (tx_q.size() > tbase) chk("req_byte", 32'(tx_q[tbase]), 32'(REQ));
    if (exp_done && tx_q.size() > tbase + 1) begin
      chk("ack_byte", 32'(tx_q[tbase + 1]), 32'(ACK));
      if (nw > 0) chk("we_before_ack", 32'(tx_cyc_q[tbase + 1] > last_we_cyc), 1);
    end
    img_q.delete();
  endtask

  initial begin
    int nt;
    int nwr;
    int sz;
    int fa;

    // Request pulse one cycle after reset release, then silence until size arrives
    do_reset(1'b0);
    tick();
    chk("req_pulse",  32'(bus.tx_start), 1);
    chk("req_sdata",  32'(bus.tx_sdata), 32'(REQ));
    tick();
    chk("req_single", 32'(bus.tx_start), 0);
    repeat (5) tick();
    chk("req_no_repeat", 32'(tx_q.size() - tbase), 1);
    img_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(32'd8, -1, 1'b0, 1'b1);
    chk("word0", (wr_data_q.size() > wbase) ? wr_data_q[wbase] : 32'hx, 32'h0000_0013);
    chk("word1", (wr_data_q.size() > wbase + 1) ? wr_data_q[wbase + 1] : 32'hx, 32'h0010_0093);

    // Bytes after completion belong to the CPU
    nt  = tx_q.size();
    nwr = wr_data_q.size();
    for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b0, 1'b1);
    repeat (3) tick();
    chk("done_ignore_tx", 32'(tx_q.size()), 32'(nt));
    chk("done_ignore_we", 32'(wr_data_q.size()), 32'(nwr));
    chk("done_sticky", 32'(bus.boot_done), 1);

    // Busy UART_TX holds off the request; bytes in S_REQ are ignored
    do_reset(1'b1);
    send_byte(8'h04, 1'b0, 1'b1);
    repeat (3) tick();
    chk("busy_holds_req", 32'(tx_q.size() - tbase), 0);
    bus.tx_busy = 1'b0;
    run_load(32'd4, -1, 1'b0, 1'b0);

    // Size checks
    do_reset(1'b0);
    run_load(32'd6, -1, 1'b0, 1'b0);
    do_reset(1'b0);
    run_load(32'h0002_0004, -1, 1'b0, 1'b1);
    do_reset(1'b0);
    run_load(32'h8000_0000, -1, 1'b0, 1'b0);
    do_reset(1'b0);
    run_load(32'd0, -1, 1'b0, 1'b0);

    // Framing error on the 3rd image byte, then clean reload
    do_reset(1'b0);
    run_load(32'd8, 2, 1'b0, 1'b0);
    do_reset(1'b0);
    run_load(32'd8, -1, 1'b0, 1'b0);
    chk("reload_err_clear", 32'(bus.boot_err), 0);

    // Reset mid-image aborts and restarts from the request
    do_reset(1'b0);
    wait_req();
    for (int k = 0; k < 4; k++) send_byte(8'(16 >> (8 * k)), 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) send_byte(8'($urandom), 1'b0, 1'b1);
    do_reset(1'b0);
    run_load(32'd12, -1, 1'b0, 1'b1);

`ifdef BOOT_CHECKSUM_EN
    do_reset(1'b0);
    img_q = '{8'h01, 8'h02, 8'h04, 8'h08};
    run_load(32'd4, -1, 1'b0, 1'b0);
    chk("csum_word_ok", (wr_data_q.size() > wbase) ? wr_data_q[wbase] : 32'hx, 32'h0804_0201);
    do_reset(1'b0);
    img_q = '{8'h01, 8'h02, 8'h04, 8'h08};
    run_load(32'd4, -1, 1'b1, 1'b0);
    chk("csum_word_bad", (wr_data_q.size() > wbase) ? wr_data_q[wbase] : 32'hx, 32'h0804_0201);
`endif

    // Randomized loads
    for (int r = 0; r < 6; r++) begin
      sz = 4 * $urandom_range(1, 12);
      fa = (r == 3) ? int'($urandom_range(0, sz - 1)) : -1;
      do_reset(1'b0);
      run_load(32'(sz), fa, r == 4, r[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
